// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl_if
// Brief   : Signal bundle between the ID/EX/MEM datapath and the hazard
//           sequencer. The optional performance counters appear only when
//           HAZARD_PERF_CNT_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if;
    // Instruction currently in ID
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_we;
    logic        id_is_load;
    logic        id_mem_access;
    // Late pipeline status
    logic        branch_taken;
    logic        dmem_ready;
    // Stage-register control
    logic        stall_if;
    logic        stall_id;
    logic        bubble_ex;
    logic        freeze_all;
    logic        flush_if_id;
    logic [1:0]  fwd_sel_a;
    logic [1:0]  fwd_sel_b;
    logic        mem_timeout;
    logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_lu_stalls;
    logic [15:0] perf_mem_waits;
    logic [15:0] perf_flushes;
`endif

    // Datapath side: supplies instruction info, consumes control strobes
    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
        output id_is_load, id_mem_access, branch_taken, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
        input  perf_lu_stalls, perf_mem_waits, perf_flushes,
`endif
        input  stall_if, stall_id, bubble_ex, freeze_all, flush_if_id,
        input  fwd_sel_a, fwd_sel_b, mem_timeout, state
    );

    // Sequencer side
    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_we,
        input  id_is_load, id_mem_access, branch_taken, dmem_ready,
`ifdef HAZARD_PERF_CNT_EN
        output perf_lu_stalls, perf_mem_waits, perf_flushes,
`endif
        output stall_if, stall_id, bubble_ex, freeze_all, flush_if_id,
        output fwd_sel_a, fwd_sel_b, mem_timeout, state
    );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : pipeline_hazard_ctrl
// Brief   : Hazard sequencer for the 4-stage pipeline (ID->EX->MEM->WB).
//           Tracks EX/MEM/WB destination info, produces stall/bubble/flush/
//           freeze strobes and registered EX forwarding selects.
//           Optional feature macro: HAZARD_PERF_CNT_EN (16-bit saturating
//           performance counters for load-use stalls, memory waits, flushes).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LU_STALL = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       mem;
    } stage_t;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [7:0] WAIT_LIMIT   = 8'(WAIT_TIMEOUT);
    localparam stage_t     BUBBLE       = '{rd: 5'd0, we: 1'b0, ld: 1'b0, mem: 1'b0};

    // Shadow stages: index 0 = EX, 1 = MEM, 2 = WB
    stage_t     pipe_q [3];
    stage_t     pipe_d [3];
    state_t     state_q, state_d;
    state_t     ret_q, ret_d;          // state to resume after a memory wait
    logic [1:0] fwd_a_q, fwd_a_d;
    logic [1:0] fwd_b_q, fwd_b_d;
    logic [2:0] flush_cnt_q, flush_cnt_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic       w_stall_if, w_stall_id, w_bubble_ex, w_freeze, w_flush;
    logic       w_wait, w_lu, w_branch_go;
    logic       w_a_ex, w_a_mem, w_b_ex, w_b_mem;
    logic [7:0] w_wait_inc;
    state_t     w_cur;
    stage_t     w_id;

    // Register x0 is hard-wired zero, so it never creates a dependency
    function automatic logic hit(input logic used, input logic [4:0] rs, input stage_t s);
        return used && s.we && (s.rd == rs) && (s.rd != 5'd0);
    endfunction

    assign w_id    = '{rd: hz.id_rd, we: hz.id_we, ld: hz.id_is_load, mem: hz.id_mem_access};
    assign w_a_ex  = hit(hz.id_rs1_used, hz.id_rs1, pipe_q[0]);
    assign w_b_ex  = hit(hz.id_rs2_used, hz.id_rs2, pipe_q[0]);
    assign w_a_mem = hit(hz.id_rs1_used, hz.id_rs1, pipe_q[1]);
    assign w_b_mem = hit(hz.id_rs2_used, hz.id_rs2, pipe_q[1]);
    assign w_lu    = pipe_q[0].ld && (w_a_ex || w_b_ex);
    assign w_wait  = pipe_q[1].mem && !hz.dmem_ready;
    // While waiting, decisions are made as if still in the interrupted state
    assign w_cur   = (state_q == ST_MEM_WAIT) ? ret_q : state_q;
    assign w_wait_inc = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

    // Next-state, shadow-stage advance and strobe generation
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        pipe_d      = pipe_q;
        fwd_a_d     = fwd_a_q;
        fwd_b_d     = fwd_b_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = 8'd0;
        timeout_d   = timeout_q;
        w_stall_if  = 1'b0;
        w_stall_id  = 1'b0;
        w_bubble_ex = 1'b0;
        w_freeze    = 1'b0;
        w_flush     = 1'b0;
        w_branch_go = 1'b0;

        if (w_wait) begin
            // Everything holds; only the wait counter moves
            w_freeze   = 1'b1;
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            state_d    = ST_MEM_WAIT;
            ret_d      = w_cur;
            wait_cnt_d = w_wait_inc;
            if (w_wait_inc == WAIT_LIMIT) begin
                timeout_d = 1'b1;
            end
        end else begin
            pipe_d[2] = pipe_q[1];
            pipe_d[1] = pipe_q[0];
            pipe_d[0] = BUBBLE;
            fwd_a_d   = 2'd0;
            fwd_b_d   = 2'd0;
            case (w_cur)
                ST_FLUSH: begin
                    // A branch seen here comes from a squashed slot
                    w_flush     = 1'b1;
                    w_bubble_ex = 1'b1;
                    if (flush_cnt_q <= 3'd1) begin
                        state_d     = ST_RUN;
                        flush_cnt_d = 3'd0;
                    end else begin
                        state_d     = ST_FLUSH;
                        flush_cnt_d = flush_cnt_q - 3'd1;
                    end
                end
                default: begin
                    if (hz.branch_taken) begin
                        w_flush     = 1'b1;
                        w_bubble_ex = 1'b1;
                        w_branch_go = 1'b1;
                        flush_cnt_d = FLUSH_RELOAD;
                        state_d     = (FLUSH_RELOAD == 3'd0) ? ST_RUN : ST_FLUSH;
                    end else if (w_lu) begin
                        w_stall_if  = 1'b1;
                        w_stall_id  = 1'b1;
                        w_bubble_ex = 1'b1;
                        state_d     = ST_LU_STALL;
                    end else begin
                        // Issue: EX producer becomes MEM (alu_out_d2),
                        // MEM producer becomes WB (_d3)
                        pipe_d[0] = w_id;
                        fwd_a_d   = w_a_ex ? 2'd1 : (w_a_mem ? 2'd2 : 2'd0);
                        fwd_b_d   = w_b_ex ? 2'd1 : (w_b_mem ? 2'd2 : 2'd0);
                        state_d   = ST_RUN;
                    end
                end
            endcase
        end
    end

    // State, shadow stages, counters and sticky error flag
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_RUN;
            ret_q       <= ST_RUN;
            pipe_q[0]   <= BUBBLE;
            pipe_q[1]   <= BUBBLE;
            pipe_q[2]   <= BUBBLE;
            fwd_a_q     <= 2'd0;
            fwd_b_q     <= 2'd0;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= 8'd0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            pipe_q      <= pipe_d;
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign hz.stall_if    = w_stall_if;
    assign hz.stall_id    = w_stall_id;
    assign hz.bubble_ex   = w_bubble_ex;
    assign hz.freeze_all  = w_freeze;
    assign hz.flush_if_id = w_flush;
    assign hz.fwd_sel_a   = fwd_a_q;
    assign hz.fwd_sel_b   = fwd_b_q;
    assign hz.mem_timeout = timeout_q;
    assign hz.state       = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] perf_lu_q, perf_mw_q, perf_fl_q;

    // Saturating event counters
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_lu_q <= 16'd0;
            perf_mw_q <= 16'd0;
            perf_fl_q <= 16'd0;
        end else begin
            if ((state_q == ST_LU_STALL) && (perf_lu_q != 16'hFFFF)) begin
                perf_lu_q <= perf_lu_q + 16'd1;
            end
            if (w_wait && (perf_mw_q != 16'hFFFF)) begin
                perf_mw_q <= perf_mw_q + 16'd1;
            end
            if (w_branch_go && (perf_fl_q != 16'hFFFF)) begin
                perf_fl_q <= perf_fl_q + 16'd1;
            end
        end
    end

    assign hz.perf_lu_stalls = perf_lu_q;
    assign hz.perf_mem_waits = perf_mw_q;
    assign hz.perf_flushes   = perf_fl_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module  : tb_pipeline_hazard_ctrl
// Brief   : Directed self-checking bench for pipeline_hazard_ctrl
//           (FLUSH_CYCLES = 2, WAIT_TIMEOUT = 255). Expected cycle results are
//           queued as each step is driven and compared once the DUT settles.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam logic [4:0] S_NO = 5'b00000;  // {stall_if, stall_id, bubble_ex, freeze_all, flush_if_id}
    localparam logic [4:0] S_LU = 5'b11100;
    localparam logic [4:0] S_FL = 5'b00101;
    localparam logic [4:0] S_WT = 5'b11010;

    typedef struct packed {
        logic [4:0] str;
        logic [1:0] st;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       to;
    } exp_t;

    logic   clock;
    logic   reset;
    int     checks;
    int     failures;
    exp_t   sb [$];

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .FLUSH_CYCLES (2),
        .WAIT_TIMEOUT (255)
    ) dut (
        .clock (clock),
        .reset (reset),
        .hz    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic we,
                          input logic ld, input logic mem);
        bus.id_rs1        = rs1;
        bus.id_rs1_used   = u1;
        bus.id_rs2        = rs2;
        bus.id_rs2_used   = u2;
        bus.id_rd         = rd;
        bus.id_we         = we;
        bus.id_is_load    = ld;
        bus.id_mem_access = mem;
    endtask

    task automatic nop();
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // One clock step: queue the expectation for the inputs just driven,
    // compare after settling, then advance to just past the next rising edge
    task automatic cyc(input string tag, input logic [4:0] es, input logic [1:0] est,
                       input logic [1:0] efa, input logic [1:0] efb, input logic eto);
        exp_t e;
        logic [4:0] got_str;
        e = '{str: es, st: est, fa: efa, fb: efb, to: eto};
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        got_str = {bus.stall_if, bus.stall_id, bus.bubble_ex, bus.freeze_all, bus.flush_if_id};
        checks++;
        assert (got_str === e.str) else begin
            failures++;
            $error("FAIL %s strobes got=%b exp=%b", tag, got_str, e.str);
        end
        checks++;
        assert (bus.state === e.st) else begin
            failures++;
            $error("FAIL %s state got=%0d exp=%0d", tag, bus.state, e.st);
        end
        checks++;
        assert ({bus.fwd_sel_a, bus.fwd_sel_b} === {e.fa, e.fb}) else begin
            failures++;
            $error("FAIL %s fwd a/b got=%0d/%0d exp=%0d/%0d", tag, bus.fwd_sel_a, bus.fwd_sel_b, e.fa, e.fb);
        end
        checks++;
        assert (bus.mem_timeout === e.to) else begin
            failures++;
            $error("FAIL %s mem_timeout got=%b exp=%b", tag, bus.mem_timeout, e.to);
        end
        @(posedge clock);
        #1;
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic chk_perf(input string tag, input logic [15:0] lu, input logic [15:0] mw,
                            input logic [15:0] fl);
        checks++;
        assert ({bus.perf_lu_stalls, bus.perf_mem_waits, bus.perf_flushes} === {lu, mw, fl}) else begin
            failures++;
            $error("FAIL %s perf lu/mw/fl got=%0d/%0d/%0d exp=%0d/%0d/%0d", tag,
                   bus.perf_lu_stalls, bus.perf_mem_waits, bus.perf_flushes, lu, mw, fl);
        end
    endtask
`endif

    initial begin
        checks           = 0;
        failures         = 0;
        reset            = 1'b1;
        bus.branch_taken = 1'b0;
        bus.dmem_ready   = 1'b1;
        nop();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state
        cyc("rst", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_rst", 16'd0, 16'd0, 16'd0);
`endif

        // Back-to-back ALU dependencies
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("alu_p", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        cyc("alu_c1", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd9, 1'b1, 5'd5, 1'b1, 5'd10, 1'b1, 1'b0, 1'b0);
        cyc("alu_c2", S_NO, 2'd0, 2'd1, 2'd0, 1'b0);
        nop();
        cyc("alu_nop", S_NO, 2'd0, 2'd0, 2'd2, 1'b0);

        // Load-use on x7 (load itself forwards x10 from MEM)
        set_id(5'd10, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        cyc("ld_p", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd7, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0);
        cyc("lu_det", S_LU, 2'd0, 2'd2, 2'd0, 1'b0);
        cyc("lu_hold", S_NO, 2'd1, 2'd0, 2'd0, 1'b0);
        nop();
        cyc("lu_after", S_NO, 2'd0, 2'd2, 2'd2, 1'b0);

        // Load to x0 followed by a reader of x0: no stall, no forward
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        cyc("x0_ld", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd0, 1'b1, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        cyc("x0_use", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        nop();
        cyc("x0_fwd", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        cyc("idle", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);

        // Taken branch: exactly two flush cycles, second branch ignored,
        // and the instruction in ID during the flush never reaches EX
        bus.branch_taken = 1'b1;
        cyc("br_take", S_FL, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        cyc("br_fl2", S_FL, 2'd3, 2'd0, 2'd0, 1'b0);
        bus.branch_taken = 1'b0;
        set_id(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("br_done", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        nop();
        cyc("br_chk", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);

        // Memory wait of 5 cycles with forwarding held and branch pending
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        cyc("mw_alu", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        cyc("mw_ld", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        set_id(5'd3, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0);
        cyc("mw_pre", S_NO, 2'd0, 2'd1, 2'd0, 1'b0);
        set_id(5'd14, 1'b1, 5'd0, 1'b0, 5'd15, 1'b1, 1'b0, 1'b0);
        bus.dmem_ready = 1'b0;
        cyc("mw_w1", S_WT, 2'd0, 2'd2, 2'd0, 1'b0);
        cyc("mw_w2", S_WT, 2'd2, 2'd2, 2'd0, 1'b0);
        bus.branch_taken = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc("mw_wbr", S_WT, 2'd2, 2'd2, 2'd0, 1'b0);
        end
        bus.dmem_ready = 1'b1;
        cyc("mw_rel", S_FL, 2'd2, 2'd2, 2'd0, 1'b0);
        bus.branch_taken = 1'b0;
        nop();
        cyc("mw_fl", S_FL, 2'd3, 2'd0, 2'd0, 1'b0);
        cyc("mw_end", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_mw", 16'd1, 16'd5, 16'd2);
`endif

        // Timeout after 255 consecutive wait cycles; flag is sticky
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        cyc("to_ld", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        nop();
        cyc("to_nop", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.dmem_ready = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            cyc("to_wait", S_WT, (k == 1) ? 2'd0 : 2'd2, 2'd0, 2'd0, 1'b0);
        end
        bus.dmem_ready = 1'b1;
        cyc("to_rel", S_NO, 2'd2, 2'd0, 2'd0, 1'b1);
        cyc("to_stk", S_NO, 2'd0, 2'd0, 2'd0, 1'b1);

        // Reset in LU_STALL clears state, forwarding and the sticky flag
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1);
        cyc("r_ldp", S_NO, 2'd0, 2'd0, 2'd0, 1'b1);
        set_id(5'd7, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        cyc("r_lud", S_LU, 2'd0, 2'd0, 2'd0, 1'b1);
        reset = 1'b1;
        cyc("r_lus", S_NO, 2'd1, 2'd0, 2'd0, 1'b1);
        reset = 1'b0;
        nop();
        cyc("r_post", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
`ifdef HAZARD_PERF_CNT_EN
        chk_perf("perf_r", 16'd0, 16'd0, 16'd0);
`endif

        // Reset in FLUSH, and reset coinciding with a taken branch
        bus.branch_taken = 1'b1;
        cyc("r_br", S_FL, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.branch_taken = 1'b0;
        reset = 1'b1;
        cyc("r_fl", S_FL, 2'd3, 2'd0, 2'd0, 1'b0);
        reset = 1'b0;
        cyc("r_post2", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.branch_taken = 1'b1;
        reset = 1'b1;
        cyc("r_br2", S_FL, 2'd0, 2'd0, 2'd0, 1'b0);
        bus.branch_taken = 1'b0;
        reset = 1'b0;
        cyc("r_post3", S_NO, 2'd0, 2'd0, 2'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
